teal_latch_bank: RTL and testbench

- Parametrised multi-channel successor to the single-event latch primitive.
- NUM_CH independent channels. Each captures a data word on a set pulse and holds it until the word is drained through a single valid/ready output port.
- Round-robin arbitration across pending channels; per-channel saturating overflow counters; selectable keep-oldest or keep-newest policy.
- Sits between DUT-side event sources and testbench monitors / interrupt logic.

---
 rtl/teal_latch_pkg.sv | 19 +
 rtl/teal_latch_chan.sv | 55 +++++
 rtl/teal_latch_bank.sv | 112 +++++++++++
 tb/tb_teal_latch_bank.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/teal_latch_pkg.sv
// Shared types and helpers for the teal_latch_bank multi-channel event latch.
package teal_latch_pkg;

  typedef logic [7:0]  uint8;
  typedef logic [15:0] uint16;
  typedef logic [31:0] uint32;
  typedef logic [63:0] uint64;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } latch_state_e;

  // A single channel still needs a 1-bit index port.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/teal_latch_chan.sv
// One latch channel: holds a captured word and its saturating overflow count
// until the arbiter drains it; clear beats load, load beats a plain set.
module teal_latch_chan
  import teal_latch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int OVF_W     = 8,
  parameter int OVERWRITE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_valid,
  input  logic [DATA_W-1:0] set_data,
  input  logic              clear,
  input  logic              load,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic [OVF_W-1:0]  ovf
);

  latch_state_e state;

  // NOTE: state registers use non-blocking assignments so every channel and
  // the output register all sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      data  <= '0;
      ovf   <= '0;
    end else if (clear) begin
      state <= EMPTY;
      ovf   <= '0;
    end else if (load) begin
      ovf <= '0;
      if (set_valid) begin
        state <= FULL;
        data  <= set_data;
      end else begin
        state <= EMPTY;
      end
    end else if (set_valid) begin
      if (state == EMPTY) begin
        state <= FULL;
        data  <= set_data;
        ovf   <= '0;
      end else begin
        if (ovf != '1) ovf <= ovf + OVF_W'(1);
        if (OVERWRITE != 0) data <= set_data;
      end
    end
  end

  assign full = (state == FULL);

endmodule

// File: rtl/teal_latch_bank.sv
// NUM_CH event latches drained round-robin through one valid/ready output
// register that snapshots the word, its source channel and overflow count.
module teal_latch_bank
  import teal_latch_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int OVF_W     = 8,
  parameter int OVERWRITE = 0,
  localparam int CH_W     = ch_idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        set_valid,
  input  logic [NUM_CH*DATA_W-1:0] set_data,
  input  logic [NUM_CH-1:0]        clear,
  output logic [NUM_CH-1:0]        pending,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [OVF_W-1:0]         out_ovf
);

  logic [NUM_CH-1:0] ch_full;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] load_vec;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [OVF_W-1:0]  ch_ovf  [NUM_CH];

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_found;
  logic              load_en;
  logic [DATA_W-1:0] sel_data;
  logic [OVF_W-1:0]  sel_ovf;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    teal_latch_chan #(
      .DATA_W    (DATA_W),
      .OVF_W     (OVF_W),
      .OVERWRITE (OVERWRITE)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .set_valid (set_valid[i]),
      .set_data  (set_data[i*DATA_W +: DATA_W]),
      .clear     (clear[i]),
      .load      (load_vec[i]),
      .full      (ch_full[i]),
      .data      (ch_data[i]),
      .ovf       (ch_ovf[i])
    );
  end

  // A channel being cleared this cycle must not be handed to the output.
  assign eligible = ch_full & ~clear;
  assign pending  = ch_full;
  assign load_en  = (!out_valid || out_ready) && (|eligible);

  // Two passes give "first at or after the pointer, else first from zero"
  // without modulo arithmetic on non-power-of-two channel counts.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && eligible[i] && (CH_W'(i) >= rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && eligible[i]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
  end

  always_comb begin
    load_vec = '0;
    sel_data = '0;
    sel_ovf  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CH_W'(i)) begin
        load_vec[i] = load_en;
        sel_data    = ch_data[i];
        sel_ovf     = ch_ovf[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_ovf   <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= grant_idx;
      out_ovf   <= sel_ovf;
      rr_ptr    <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_teal_latch_bank.sv
// Directed bench for teal_latch_bank: default build plus keep-newest and
// 2-bit-overflow builds driven by identical stimulus.
module tb_teal_latch_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   set_valid;
  logic [127:0] set_data;
  logic [3:0]   clear;
  logic         out_ready;

  logic [3:0]  pending,   pending_ow,   pending_sat;
  logic        out_valid, out_valid_ow, out_valid_sat;
  logic [31:0] out_data,  out_data_ow,  out_data_sat;
  logic [1:0]  out_ch,    out_ch_ow,    out_ch_sat;
  logic [7:0]  out_ovf,   out_ovf_ow;
  logic [1:0]  out_ovf_sat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  teal_latch_bank dut (
    .clk(clk), .reset(reset), .set_valid(set_valid), .set_data(set_data),
    .clear(clear), .pending(pending), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_ovf(out_ovf)
  );

  teal_latch_bank #(.OVERWRITE(1)) dut_ow (
    .clk(clk), .reset(reset), .set_valid(set_valid), .set_data(set_data),
    .clear(clear), .pending(pending_ow), .out_valid(out_valid_ow),
    .out_ready(out_ready), .out_data(out_data_ow), .out_ch(out_ch_ow),
    .out_ovf(out_ovf_ow)
  );

  teal_latch_bank #(.OVF_W(2)) dut_sat (
    .clk(clk), .reset(reset), .set_valid(set_valid), .set_data(set_data),
    .clear(clear), .pending(pending_sat), .out_valid(out_valid_sat),
    .out_ready(out_ready), .out_data(out_data_sat), .out_ch(out_ch_sat),
    .out_ovf(out_ovf_sat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] d);
    set_valid[ch] = 1'b1;
    set_data[ch*32 +: 32] = d;
  endtask

  task automatic idle();
    set_valid = '0;
  endtask

  initial begin
    reset = 1'b1; set_valid = '0; set_data = '0; clear = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_pending",   pending,   4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  32'h0);
    check("rst_out_ch",    out_ch,    2'd0);
    check("rst_out_ovf",   out_ovf,   8'd0);
    reset = 1'b0;

    // single capture on channel 2
    out_ready = 1'b1;
    set_ch(2, 32'hDEADBEEF); tick(); idle();
    check("cap_pending",   pending,   4'b0100);
    check("cap_not_yet",   out_valid, 1'b0);
    tick();
    check("cap_valid",     out_valid, 1'b1);
    check("cap_data",      out_data,  32'hDEADBEEF);
    check("cap_ch",        out_ch,    2'd2);
    check("cap_ovf",       out_ovf,   8'd0);
    check("cap_drained",   pending,   4'b0000);
    tick();
    check("drain_invalid", out_valid, 1'b0);
    check("drain_hold",    out_data,  32'hDEADBEEF);

    // overflow on ch0 while the output register is held by ch3
    out_ready = 1'b0;
    set_ch(3, 32'h33); tick(); idle(); tick();
    check("ovf_blocker_ch", out_ch, 2'd3);
    for (int i = 1; i <= 3; i++) begin
      set_ch(0, 32'(i)); tick();
    end
    idle();
    check("ovf_pending",    pending, 4'b0001);
    check("ovf_held_ch",    out_ch,  2'd3);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("ovf_ch",         out_ch,      2'd0);
    check("ovf_keep_old",   out_data,    32'h1);
    check("ovf_count",      out_ovf,     8'd2);
    check("ovf_keep_new",   out_data_ow, 32'h3);
    check("ovf_count_ow",   out_ovf_ow,  8'd2);
    set_ch(0, 32'h4); tick(); idle();
    out_ready = 1'b1; tick();
    check("recap_data",     out_data, 32'h4);
    check("recap_ovf",      out_ovf,  8'd0);
    tick();
    check("recap_empty",    out_valid, 1'b0);

    // saturation on ch3 behind a stalled ch1 word
    out_ready = 1'b0;
    set_ch(1, 32'hA1); tick(); idle(); tick();
    check("sat_blocker_ch", out_ch, 2'd1);
    for (int i = 0; i < 7; i++) begin
      set_ch(3, 32'h100 + 32'(i)); tick();
      if (i < 5) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data",  out_data,  32'hA1);
        check("stall_ch",    out_ch,    2'd1);
      end
    end
    idle();
    out_ready = 1'b1; tick();
    check("sat_ch",         out_ch,       2'd3);
    check("sat_ovf_2b",     out_ovf_sat,  2'd3);
    check("sat_ovf_8b",     out_ovf,      8'd6);
    check("sat_data_old",   out_data,     32'h100);
    check("sat_data_new",   out_data_ow,  32'h106);
    tick();
    check("sat_empty",      out_valid, 1'b0);

    // round robin from pointer 0, refilling ch0/ch1 while ch1 drains
    for (int i = 0; i < 4; i++) set_ch(i, 32'hC0 + 32'(i));
    tick(); idle();
    check("rr_pending",     pending, 4'b1111);
    tick();
    check("rr_g0_ch",       out_ch,   2'd0);
    check("rr_g0_data",     out_data, 32'hC0);
    set_ch(0, 32'hD0); set_ch(1, 32'hD1); tick(); idle();
    check("rr_g1_ch",       out_ch,   2'd1);
    check("rr_g1_data",     out_data, 32'hC1);
    check("rr_refill_pend", pending,  4'b1111);
    tick();
    check("rr_g2_ch",       out_ch, 2'd2);
    tick();
    check("rr_g3_ch",       out_ch, 2'd3);
    tick();
    check("rr_g4_ch",       out_ch,   2'd0);
    check("rr_g4_data",     out_data, 32'hD0);
    tick();
    check("rr_g5_ch",       out_ch,   2'd1);
    check("rr_g5_data",     out_data, 32'hD1);
    check("rr_g5_ovf",      out_ovf,  8'd0);
    tick();
    check("rr_empty",       out_valid, 1'b0);

    // clear beats set on the same channel and wipes its overflow count
    out_ready = 1'b0;
    set_ch(3, 32'hE3); tick(); idle(); tick();
    check("clr_blocker_ch", out_ch, 2'd3);
    set_ch(1, 32'h1); tick(); set_ch(1, 32'h2); tick(); idle();
    check("clr_pre_pend",   pending, 4'b0010);
    set_ch(1, 32'h3); clear = 4'b0010; tick(); idle(); clear = '0;
    check("clr_pending",    pending, 4'b0000);
    set_ch(1, 32'hF1); tick(); idle();
    out_ready = 1'b1; tick();
    check("clr_recap_ch",   out_ch,   2'd1);
    check("clr_recap_data", out_data, 32'hF1);
    check("clr_recap_ovf",  out_ovf,  8'd0);
    tick();
    check("clr_empty",      out_valid, 1'b0);
    set_ch(2, 32'h22); tick(); idle();
    clear = 4'b0100; tick(); clear = '0;
    check("clr_blocks_load", out_valid, 1'b0);
    check("clr_blocks_pend", pending,   4'b0000);

    // asynchronous reset in the middle of a stalled word
    out_ready = 1'b0;
    set_ch(1, 32'hB1); tick(); idle();
    set_ch(2, 32'hB2); tick(); idle();
    check("arst_pre_valid", out_valid, 1'b1);
    check("arst_pre_pend",  pending,   4'b0100);
    #3 reset = 1'b1;
    #1;
    check("arst_valid",     out_valid, 1'b0);
    check("arst_pending",   pending,   4'b0000);
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    set_ch(0, 32'hA0); set_ch(3, 32'hA3); tick(); idle();
    tick();
    check("arst_first_ch",   out_ch,   2'd0);
    check("arst_first_data", out_data, 32'hA0);
    tick();
    check("arst_second_ch",  out_ch,   2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
